// File: rtl/terminal_access_if.sv
// Terminal-side signal bundle: two terminals' switches and request buttons in,
// grant pulses and the latched display result out.
interface terminal_access_if;
  logic [3:0] hh0;
  logic [1:0] b0;
  logic       req0_n;
  logic [3:0] hh1;
  logic [1:0] b1;
  logic       req1_n;
  logic       ack0;
  logic       ack1;
  logic       valid;
  logic       term_sel;
  logic [2:0] user_id;
  logic [2:0] func_id;
  logic       auth_ok;
  logic [1:0] pending;

  modport master (
    output hh0, b0, req0_n, hh1, b1, req1_n,
    input  ack0, ack1, valid, term_sel, user_id, func_id, auth_ok, pending
  );

  modport slave (
    input  hh0, b0, req0_n, hh1, b1, req1_n,
    output ack0, ack1, valid, term_sel, user_id, func_id, auth_ok, pending
  );
endinterface

// File: rtl/terminal_access_controller.sv
// Debounces both terminals' request buttons, arbitrates round-robin, latches and
// authenticates the granted user code, and holds the result for HOLD_CYCLES.
module terminal_access_controller #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter logic [7:0]  AUTH_MASK   = 8'b11111110
) (
  input  logic clk,
  input  logic rst_n,
  terminal_access_if.slave bus
);

  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]        w_req_raw;
  logic [1:0]        r_sync_a;
  logic [1:0]        r_sync_b;
  logic [1:0]        w_press;
  logic [1:0]        r_press;
  logic [1:0]        r_pending;
  logic              r_rr;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [1:0]        r_ack;
  logic              r_valid;
  logic              r_term;
  logic [2:0]        r_user;
  logic [2:0]        r_func;
  logic              r_auth;

  logic              w_grant_en;
  logic              w_hold_done;
  logic              w_grant;
  logic [1:0]        w_grant_oh;
  logic [3:0]        w_sel_hh;
  logic [1:0]        w_sel_b;

  assign w_req_raw = {bus.req1_n, bus.req0_n};

  // Two-flop synchroniser; reset to the released (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_a <= '1;
      r_sync_b <= '1;
    end else begin
      r_sync_a <= w_req_raw;
      r_sync_b <= r_sync_a;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic [DEB_W-1:0] r_cnt;
    logic             r_stable;
    logic             w_differ;
    logic             w_flip;

    assign w_differ = (~r_sync_b[g]) != r_stable;
    assign w_flip   = w_differ && (r_cnt == DEB_LAST);
    assign w_press[g] = w_flip & ~r_stable;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (w_differ) begin
        if (w_flip) begin
          r_cnt    <= '0;
          r_stable <= ~r_stable;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_hold_done = 1'b0;
    // Both waiting: serve the terminal that was not served last
    w_grant     = (r_pending == 2'b11) ? ~r_rr : r_pending[1];
    case (r_state)
      S_IDLE: begin
        if (r_pending != 2'b00) begin
          w_grant_en  = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == '0) begin
          w_hold_done = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_grant_oh = w_grant ? 2'b10 : 2'b01;
  assign w_sel_hh   = w_grant ? bus.hh1 : bus.hh0;
  assign w_sel_b    = w_grant ? bus.b1  : bus.b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press <= '0;
    end else begin
      r_press <= w_press;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_rr       <= 1'b1;
      r_hold_cnt <= '0;
      r_ack      <= '0;
      r_valid    <= 1'b0;
      r_term     <= 1'b0;
      r_user     <= '0;
      r_func     <= '0;
      r_auth     <= 1'b0;
    end else begin
      r_ack     <= '0;
      // A press landing on the edge its own request is granted merges into that grant
      r_pending <= (r_pending | r_press) & ~(w_grant_en ? w_grant_oh : 2'b00);
      if (w_grant_en) begin
        r_ack      <= w_grant_oh;
        r_valid    <= 1'b1;
        r_term     <= w_grant;
        r_user     <= w_sel_hh[2:0];
        r_func     <= {w_sel_hh[3], w_sel_b};
        r_auth     <= AUTH_MASK[w_sel_hh[2:0]];
        r_rr       <= w_grant;
        r_hold_cnt <= HOLD_LOAD;
      end else if (r_state == S_HOLD) begin
        if (w_hold_done) begin
          r_valid <= 1'b0;
        end else begin
          r_hold_cnt <= r_hold_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.ack0     = r_ack[0];
  assign bus.ack1     = r_ack[1];
  assign bus.valid    = r_valid;
  assign bus.term_sel = r_term;
  assign bus.user_id  = r_user;
  assign bus.func_id  = r_func;
  assign bus.auth_ok  = r_auth;
  assign bus.pending  = r_pending;

endmodule

// File: tb/tb_terminal_access_controller.sv
// Randomised and directed bench for terminal_access_controller, checked every
// cycle against a behavioural model of debounce, arbitration and hold timing.
module tb_terminal_access_controller;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam logic [7:0] MASK = 8'b11111110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  terminal_access_if bus ();

  terminal_access_controller #(
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD),
    .AUTH_MASK  (MASK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit       m_s1 [2] = '{1'b1, 1'b1};
  bit       m_s2 [2] = '{1'b1, 1'b1};
  bit       m_acc[2] = '{1'b0, 1'b0};
  int       m_run[2] = '{0, 0};
  bit [1:0] m_ev   = '0;
  bit [1:0] m_pend = '0;
  bit       m_rr   = 1'b1;
  int       m_left = 0;
  bit [1:0] e_ack  = '0;
  bit [2:0] e_user = '0;
  bit [2:0] e_func = '0;
  bit       e_auth = 1'b0;
  bit       e_term = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < 2; t++) begin
        m_s1[t] = 1'b1; m_s2[t] = 1'b1; m_acc[t] = 1'b0; m_run[t] = 0;
      end
      m_ev = '0; m_pend = '0; m_rr = 1'b1; m_left = 0; e_ack = '0;
      e_user = '0; e_func = '0; e_auth = 1'b0; e_term = 1'b0;
    end else begin
      bit [1:0] gmask;
      bit [3:0] hh;
      bit [1:0] bb;
      bit       raw [2];
      int       g;
      gmask = '0;
      e_ack = '0;
      if (m_left == 0 && m_pend != 0) begin
        if (m_pend == 2'b11) g = m_rr ? 0 : 1;
        else g = m_pend[1] ? 1 : 0;
        hh = (g == 1) ? bus.hh1 : bus.hh0;
        bb = (g == 1) ? bus.b1 : bus.b0;
        e_user = hh[2:0];
        e_func = {hh[3], bb};
        e_auth = MASK[hh[2:0]];
        e_term = (g == 1);
        m_rr = (g == 1);
        m_left = HOLD;
        e_ack[g] = 1'b1;
        gmask[g] = 1'b1;
      end else if (m_left > 0) begin
        m_left--;
      end
      m_pend = (m_pend | m_ev) & ~gmask;
      raw[0] = bus.req0_n;
      raw[1] = bus.req1_n;
      for (int t = 0; t < 2; t++) begin
        bit pressed;
        pressed = !m_s2[t];
        m_ev[t] = 1'b0;
        if (pressed != m_acc[t]) begin
          m_run[t]++;
          if (m_run[t] == DEB) begin
            m_acc[t] = pressed;
            m_run[t] = 0;
            m_ev[t] = pressed;
          end
        end else begin
          m_run[t] = 0;
        end
        m_s2[t] = m_s1[t];
        m_s1[t] = raw[t];
      end
    end
  end

  // Per-cycle comparison plus activity log
  int cyc = 0;
  int n_valid = 0;
  int ack_t[$];
  int ack_c[$];

  always @(negedge clk) begin
    cyc++;
    chk("ack0",     int'(bus.ack0),     int'(e_ack[0]));
    chk("ack1",     int'(bus.ack1),     int'(e_ack[1]));
    chk("valid",    int'(bus.valid),    (m_left > 0) ? 1 : 0);
    chk("pending",  int'(bus.pending),  int'(m_pend));
    chk("term_sel", int'(bus.term_sel), int'(e_term));
    chk("user_id",  int'(bus.user_id),  int'(e_user));
    chk("func_id",  int'(bus.func_id),  int'(e_func));
    chk("auth_ok",  int'(bus.auth_ok),  int'(e_auth));
    if (bus.ack0 && bus.ack1) chk("ack_exclusive", 1, 0);
    if (bus.ack0) begin ack_t.push_back(0); ack_c.push_back(cyc); end
    if (bus.ack1) begin ack_t.push_back(1); ack_c.push_back(cyc); end
    if (bus.valid) n_valid++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_acks(input string name, input int want, input int budget);
    int k = 0;
    while (ack_t.size() < want && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, ack_t.size(), want);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
    tick(2);
  endtask

  int a0, v0, seg0, seg1;

  initial begin
    bus.hh0 = '0; bus.b0 = '0; bus.req0_n = 1'b1;
    bus.hh1 = '0; bus.b1 = '0; bus.req1_n = 1'b1;

    // Reset with random inputs, then quiet release
    rst_n = 1'b0;
    repeat (6) begin
      bus.hh0 = 4'($urandom); bus.b0 = 2'($urandom); bus.req0_n = 1'($urandom);
      bus.hh1 = 4'($urandom); bus.b1 = 2'($urandom); bus.req1_n = 1'($urandom);
      tick(1);
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_user", int'(bus.user_id), 0);
    end
    bus.req0_n = 1'b1; bus.req1_n = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(15);
    chk("idle_no_ack", ack_t.size(), 0);
    chk("idle_valid", int'(bus.valid), 0);

    // Basic grant
    a0 = ack_t.size(); v0 = n_valid;
    bus.hh0 = 4'b1011; bus.b0 = 2'b10; bus.req0_n = 1'b0;
    tick(20);
    bus.req0_n = 1'b1;
    tick(25);
    chk("basic_ack_count", ack_t.size() - a0, 1);
    chk("basic_ack_term", ack_t[a0], 0);
    chk("basic_valid_len", n_valid - v0, 8);
    chk("basic_user", int'(bus.user_id), 3);
    chk("basic_func", int'(bus.func_id), 6);
    chk("basic_auth", int'(bus.auth_ok), 1);
    chk("basic_term", int'(bus.term_sel), 0);
    chk("model_pin_user", int'(e_user), 3);
    chk("model_pin_func", int'(e_func), 6);

    // Bounce on terminal 1: low pulses too short to debounce
    a0 = ack_t.size();
    for (int i = 0; i < 10; i++) begin
      bus.req1_n = 1'b0;
      tick($urandom_range(1, 3));
      bus.req1_n = 1'b1;
      tick($urandom_range(1, 3));
    end
    tick(10);
    chk("bounce_no_ack", ack_t.size() - a0, 0);
    chk("bounce_pending", int'(bus.pending), 0);
    chk("bounce_valid", int'(bus.valid), 0);

    // Simultaneous presses after reset: terminal 0 first, one idle cycle gap
    do_reset(2);
    a0 = ack_t.size();
    bus.hh0 = 4'b0101; bus.b0 = 2'b01; bus.hh1 = 4'b1110; bus.b1 = 2'b11;
    bus.req0_n = 1'b0; bus.req1_n = 1'b0;
    wait_acks("simul_acks", a0 + 2, 60);
    chk("simul_first", ack_t[a0], 0);
    chk("simul_second", ack_t[a0 + 1], 1);
    chk("simul_gap", ack_c[a0 + 1] - ack_c[a0], 9);
    bus.req0_n = 1'b1; bus.req1_n = 1'b1;
    tick(12);
    chk("simul_user1", int'(bus.user_id), 6);
    chk("simul_func1", int'(bus.func_id), 7);
    a0 = ack_t.size();
    bus.req0_n = 1'b0; bus.req1_n = 1'b0;
    wait_acks("simul_again", a0 + 2, 60);
    chk("rr_first_again", ack_t[a0], 0);
    bus.req0_n = 1'b1; bus.req1_n = 1'b1;
    tick(20);

    // Unauthorised user 0 on terminal 1
    a0 = ack_t.size(); v0 = n_valid;
    bus.hh1 = 4'b1000; bus.b1 = 2'b01; bus.req1_n = 1'b0;
    wait_acks("unauth_ack", a0 + 1, 40);
    bus.req1_n = 1'b1;
    tick(14);
    chk("unauth_term", ack_t[a0], 1);
    chk("unauth_user", int'(bus.user_id), 0);
    chk("unauth_auth", int'(bus.auth_ok), 0);
    chk("unauth_func", int'(bus.func_id), 5);
    chk("unauth_valid_len", n_valid - v0, 8);

    // Reset in the third valid cycle with terminal 1 still pending
    do_reset(2);
    a0 = ack_t.size();
    bus.req0_n = 1'b0; bus.req1_n = 1'b0;
    wait_acks("midrst_ack", a0 + 1, 40);
    tick(2);
    chk("midrst_pend_before", int'(bus.pending), 2);
    chk("midrst_valid_before", int'(bus.valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(bus.valid), 0);
    chk("midrst_pending", int'(bus.pending), 0);
    chk("midrst_user", int'(bus.user_id), 0);
    chk("midrst_term", int'(bus.term_sel), 0);
    bus.req0_n = 1'b1; bus.req1_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    a0 = ack_t.size();
    tick(30);
    chk("midrst_no_ack", ack_t.size() - a0, 0);

    // Randomised traffic
    seg0 = 0; seg1 = 0;
    for (int c = 0; c < 1500; c++) begin
      if (seg0 == 0) begin bus.req0_n = 1'($urandom); seg0 = $urandom_range(1, 14); end
      if (seg1 == 0) begin bus.req1_n = 1'($urandom); seg1 = $urandom_range(1, 14); end
      seg0--; seg1--;
      if ($urandom_range(0, 7) == 0) begin bus.hh0 = 4'($urandom); bus.b0 = 2'($urandom); end
      if ($urandom_range(0, 7) == 0) begin bus.hh1 = 4'($urandom); bus.b1 = 2'($urandom); end
      if (c == 700) rst_n = 1'b0;
      if (c == 702) rst_n = 1'b1;
      tick(1);
    end
    bus.req0_n = 1'b1; bus.req1_n = 1'b1;
    tick(40);
    chk("final_idle_valid", int'(bus.valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
